// File: rtl/ddr_txser.sv
// ddr_txser: transmit serializer for a DDR output pad, MSB-first, two bits per clock, plus forwarded clock.
// Defining DDRSER_CSN_EN adds o_csn framing with one lead and one trail cycle around each burst.
module ddr_txser #(
    parameter int   DW   = 8,
    parameter logic IDLE = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_stb,
    input  logic [DW-1:0] i_data,
    output logic          o_busy,
    output logic [1:0]    o_ddr,
    output logic [1:0]    o_ckout,
    output logic          o_active,
`ifdef DDRSER_CSN_EN
    output logic          o_csn,
`endif
    output logic          o_done
);
    localparam int BEATS = DW / 2;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LEAD, S_TRAIL} state_t;

    state_t        state, state_next;
    logic [DW-1:0] sreg, sreg_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [1:0]    ddr_next, ckout_next;
    logic          active_next, done_next;
    logic          accept, last;
`ifdef DDRSER_CSN_EN
    logic          csn_next;
`endif

    // cnt counts beats still to come after the one currently on o_ddr
    assign last   = (cnt == '0);
    assign o_busy = (state == S_SHIFT && !last) || (state == S_LEAD) || (state == S_TRAIL);
    assign accept = i_stb && !o_busy;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef DDRSER_CSN_EN
                    state_next = S_LEAD;
`else
                    state_next = S_SHIFT;
`endif
                end
            end
            S_SHIFT: begin
                if (last && !accept) begin
`ifdef DDRSER_CSN_EN
                    state_next = S_TRAIL;
`else
                    state_next = S_IDLE;
`endif
                end
            end
`ifdef DDRSER_CSN_EN
            S_LEAD:  state_next = S_SHIFT;
            S_TRAIL: state_next = S_IDLE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Next values for the registered outputs: the first beat is launched directly
    // from i_data at accept so it appears on o_ddr in the very next cycle.
    always_comb begin
        sreg_next   = sreg;
        cnt_next    = cnt;
        ddr_next    = {IDLE, IDLE};
        ckout_next  = 2'b00;
        active_next = 1'b0;
        done_next   = 1'b0;
`ifdef DDRSER_CSN_EN
        csn_next    = o_csn;
`endif
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef DDRSER_CSN_EN
                    sreg_next   = i_data;
                    csn_next    = 1'b0;
`else
                    ddr_next    = {i_data[DW-2], i_data[DW-1]};
                    sreg_next   = i_data << 2;
                    cnt_next    = LAST_CNT;
                    ckout_next  = 2'b10;
                    active_next = 1'b1;
`endif
                end
            end
            S_SHIFT: begin
                if (!last) begin
                    ddr_next    = {sreg[DW-2], sreg[DW-1]};
                    sreg_next   = sreg << 2;
                    cnt_next    = cnt - 1'b1;
                    ckout_next  = 2'b10;
                    active_next = 1'b1;
                end else if (accept) begin
                    ddr_next    = {i_data[DW-2], i_data[DW-1]};
                    sreg_next   = i_data << 2;
                    cnt_next    = LAST_CNT;
                    ckout_next  = 2'b10;
                    active_next = 1'b1;
                end else begin
`ifndef DDRSER_CSN_EN
                    done_next   = 1'b1;
`endif
                end
            end
`ifdef DDRSER_CSN_EN
            S_LEAD: begin
                ddr_next    = {sreg[DW-2], sreg[DW-1]};
                sreg_next   = sreg << 2;
                cnt_next    = LAST_CNT;
                ckout_next  = 2'b10;
                active_next = 1'b1;
            end
            S_TRAIL: begin
                csn_next    = 1'b1;
                done_next   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sreg     <= '0;
            cnt      <= '0;
            o_ddr    <= {IDLE, IDLE};
            o_ckout  <= 2'b00;
            o_active <= 1'b0;
            o_done   <= 1'b0;
`ifdef DDRSER_CSN_EN
            o_csn    <= 1'b1;
`endif
        end else begin
            sreg     <= sreg_next;
            cnt      <= cnt_next;
            o_ddr    <= ddr_next;
            o_ckout  <= ckout_next;
            o_active <= active_next;
            o_done   <= done_next;
`ifdef DDRSER_CSN_EN
            o_csn    <= csn_next;
`endif
        end
    end
endmodule
